cram_hybrid_ctrl: RTL
=====================

Name: cram_hybrid_ctrl

Overview:
- Flow-control wrapper around the pipelined hybrid Benes crossbar (cram_hybrid); sits directly upstream of it and consumes its output.
- Accepts one permutation transaction per cycle on valid/ready, skews per-stage switch selects to match the crossbar's internal data registers, and tracks validity through the fixed crossbar latency.
- Captures crossbar output into an output FIFO guarded by an outstanding-transaction credit count, so downstream backpressure never drops in-flight data.

Parameters:
- XREQ_SIZE, `XBOT (32): crossbar ports; power of two, >=4.
- XDATA_SIZE, `DATA (128): bits per port.
- LOG_XREQ_SIZE, `LOG_REQ (5): log2(XREQ_SIZE).
- FIFO_DEPTH, 2*LOG_XREQ_SIZE (10): output FIFO entries, >=1. Full throughput requires FIFO_DEPTH >= LAT+2.
- Derived: LAT = 2*(LOG_XREQ_SIZE-1) (crossbar latency); NSTG = 2*LOG_XREQ_SIZE-1 (select stages).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  transaction offered
- req_ready  out  1  transaction can be accepted
- req_data  in  [XREQ_SIZE-1:0][XDATA_SIZE-1:0]  input vector
- req_sel  in  [NSTG-1:0][XREQ_SIZE/2-1:0]  switch settings for all stages of this transaction
- xbar_in  out  [XREQ_SIZE-1:0][XDATA_SIZE-1:0]  to crossbar in
- xbar_sel  out  [NSTG-1:0][XREQ_SIZE/2-1:0]  to crossbar sel
- xbar_out  in  [XREQ_SIZE-1:0][XDATA_SIZE-1:0]  from crossbar out
- rsp_valid  out  1  FIFO head valid
- rsp_ready  in  1  downstream accepts head
- rsp_data  out  [XREQ_SIZE-1:0][XDATA_SIZE-1:0]  FIFO head

Behaviour:
- Accept: acc = req_valid && req_ready. Pop: pop = rsp_valid && rsp_ready.
- req_ready = (outstanding < FIFO_DEPTH). There is no same-cycle pop lookahead. outstanding counts accepted-but-not-popped transactions and needs $clog2(FIFO_DEPTH+1) bits.
- outstanding update: +1 on acc only; -1 on pop only; unchanged when both or neither occur. It never overflows or underflows; a violation is an assertion failure.
- xbar_in = acc ? req_data : 0 (combinational). The zeroing on non-accept cycles is mandatory.
- Select skew: xbar_sel[0] = req_sel[0] (combinational). For stage s = 1..NSTG-1, xbar_sel[s] = req_sel[s] delayed by s cycles through an s-deep register chain, advanced every cycle. The last stage (NSTG-1) is delayed LAT cycles and is combinational in the crossbar.
- Valid tracking: LAT-bit shift register vsr, with vsr[0] <= acc each cycle. When vsr[LAT-1] is set, xbar_out is valid in that cycle and is pushed into the FIFO at the next edge.
- Latency: accept in cycle t -> rsp_valid earliest in cycle t+LAT+1 (registered FIFO, no fall-through).
- FIFO: FIFO_DEPTH entries, in-order, wrap-around pointers. Push and pop in the same cycle are allowed, including when the FIFO is full or holds one entry. A push never finds the FIFO full (guaranteed by credit); assert this.
- rsp_data is valid only while rsp_valid is high. It holds steady while rsp_valid && !rsp_ready.
- Reset values: req_ready=1 after reset cycle; rsp_valid=0; rsp_data=0; outstanding=0; vsr=0; all sel skew registers=0; FIFO pointers=0.
- Reset mid-operation: everything is flushed, including the crossbar's own pipeline on the shared rst. No response emerges for transactions accepted before reset.

Optional Feature:
- Macro CRAM_CTRL_PERF_EN.
- Defined: adds outputs perf_accept_cnt [31:0] (acc cycles) and perf_stall_cnt [31:0] (req_valid && !req_ready cycles). Both are cleared by rst and saturate at 0xFFFFFFFF.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cram_pkg: LAT/NSTG derivation functions, data-vector typedef, sel-vector typedef.
- One sub-module, cram_out_fifo: parameterised synchronous FIFO with push/pop/full/empty and registered head.

Test Plan (LOG_XREQ_SIZE=5, LAT=8, FIFO_DEPTH=10, golden model = cram_hybrid behavioural reference):
- Single request, rsp_ready=1, accepted at cycle 0 with random data/sel -> rsp_valid first at cycle 9. rsp_data equals a fully-combinational Benes route of the same data/sel.
- Back-to-back 100 requests, rsp_ready=1 -> req_ready never drops, one response per cycle, order preserved, all match golden.
- rsp_ready=0, req_valid=1 continuously -> exactly 10 accepted, then req_ready=0. After rsp_ready=1, all 10 drain in order with no loss.
- Simultaneous accept and pop with outstanding=10-1 -> outstanding stays 9, req_ready stays 1.
- rst asserted at cycle 4 after 3 accepts -> rsp_valid stays 0 thereafter, outstanding=0, req_ready=1 the cycle after reset.
- Changing req_sel every cycle (stage s set to pattern s^cycle) -> each response uses only its own transaction's selects at every stage.

Source files
------------

// File: rtl/cram_hybrid_ctrl_pkg.sv
// cram_pkg: shared definitions for the hybrid Benes crossbar controller.
//   - cram_lat / cram_nstg derive crossbar latency and select-stage count
//     from log2(port count).
//   - cram_data_t / cram_sel_t are the data and select vectors for the
//     default 32-port, 128-bit configuration.
package cram_pkg;

  localparam int CRAM_XREQ_SIZE     = 32;
  localparam int CRAM_XDATA_SIZE    = 128;
  localparam int CRAM_LOG_XREQ_SIZE = 5;

  // Pipeline registers sit between every pair of stages except the last,
  // which is combinational inside the crossbar.
  function automatic int cram_lat(input int log_n);
    return 2 * (log_n - 1);
  endfunction

  function automatic int cram_nstg(input int log_n);
    return 2 * log_n - 1;
  endfunction

  localparam int CRAM_LAT  = cram_lat(CRAM_LOG_XREQ_SIZE);
  localparam int CRAM_NSTG = cram_nstg(CRAM_LOG_XREQ_SIZE);

  typedef logic [CRAM_XREQ_SIZE-1:0][CRAM_XDATA_SIZE-1:0] cram_data_t;
  typedef logic [CRAM_NSTG-1:0][CRAM_XREQ_SIZE/2-1:0]     cram_sel_t;

endpackage

// File: rtl/cram_hybrid_ctrl_out_fifo.sv
// cram_out_fifo: synchronous in-order FIFO with wrap-around pointers.
// The head comes straight from the storage flops (no fall-through), so an
// entry pushed at an edge is visible on head from the following cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push/push_data write one entry (must not be full)
//   pop            consume head (ignored when empty)
//   full/empty     occupancy flags
//   head           oldest entry; zero after reset
module cram_out_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    pop_ok;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign head   = mem_q[rd_ptr_q];
  assign pop_ok = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop_ok)      cnt_d = cnt_q + CW'(1);
    else if (pop_ok && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/cram_hybrid_ctrl.sv
// cram_hybrid_ctrl: valid/ready wrapper around the pipelined hybrid Benes
// crossbar. Accepts one permutation per cycle, skews per-stage selects to
// line up with the crossbar's data registers, tracks validity through the
// fixed crossbar latency and lands results in an output FIFO. Acceptance is
// credit-limited by outstanding transactions, so backpressure never drops
// data already inside the crossbar.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_data, req_sel           input vector and all-stage switch settings
//   xbar_in, xbar_sel           drive the crossbar
//   xbar_out                    crossbar result (valid LAT cycles after in)
//   rsp_valid/rsp_ready         response handshake
//   rsp_data                    FIFO head
//   perf_accept_cnt, perf_stall_cnt   only with CRAM_CTRL_PERF_EN defined
// Optional macro: CRAM_CTRL_PERF_EN adds saturating accept/stall counters.
module cram_hybrid_ctrl
  import cram_pkg::*;
#(
  parameter  int XREQ_SIZE     = CRAM_XREQ_SIZE,
  parameter  int XDATA_SIZE    = CRAM_XDATA_SIZE,
  parameter  int LOG_XREQ_SIZE = CRAM_LOG_XREQ_SIZE,
  parameter  int FIFO_DEPTH    = 2 * LOG_XREQ_SIZE,
  localparam int LAT           = cram_lat(LOG_XREQ_SIZE),
  localparam int NSTG          = cram_nstg(LOG_XREQ_SIZE),
  localparam int HALF          = XREQ_SIZE / 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic [XREQ_SIZE-1:0][XDATA_SIZE-1:0]  req_data,
  input  logic [NSTG-1:0][HALF-1:0]             req_sel,
  output logic [XREQ_SIZE-1:0][XDATA_SIZE-1:0]  xbar_in,
  output logic [NSTG-1:0][HALF-1:0]             xbar_sel,
  input  logic [XREQ_SIZE-1:0][XDATA_SIZE-1:0]  xbar_out,
  output logic                                  rsp_valid,
  input  logic                                  rsp_ready,
  output logic [XREQ_SIZE-1:0][XDATA_SIZE-1:0]  rsp_data
`ifdef CRAM_CTRL_PERF_EN
  ,
  output logic [31:0]                           perf_accept_cnt,
  output logic [31:0]                           perf_stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          acc, pop, push, fifo_full, fifo_empty;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [LAT-1:0] vsr_q, vsr_d;

  // Credit check counts everything accepted but not yet popped, so every
  // transaction inside the crossbar already owns a FIFO slot.
  assign req_ready = (outstanding_q < CW'(FIFO_DEPTH));
  assign acc       = req_valid && req_ready;
  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign push      = vsr_q[LAT-1];

  // Idle cycles feed zeros so stale data never wanders through the crossbar.
  assign xbar_in = acc ? req_data : '0;

  always_comb begin
    outstanding_d = outstanding_q;
    if (acc && !pop)      outstanding_d = outstanding_q + CW'(1);
    else if (pop && !acc) outstanding_d = outstanding_q - CW'(1);
    vsr_d = {vsr_q[LAT-2:0], acc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= '0;
      vsr_q         <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      vsr_q         <= vsr_d;
    end
  end

  // Stage s of the crossbar sees this transaction's data s cycles after
  // entry, so its select goes through an s-deep chain. Chains advance every
  // cycle; idle cycles just carry don't-care selects alongside zero data.
  assign xbar_sel[0] = req_sel[0];

  for (genvar s = 1; s < NSTG; s++) begin : g_skew
    logic [s-1:0][HALF-1:0] sk_q, sk_d;

    always_comb begin
      sk_d    = sk_q;
      sk_d[0] = req_sel[s];
      for (int k = 1; k < s; k++) sk_d[k] = sk_q[k-1];
    end

    always_ff @(posedge clk) begin
      if (rst) sk_q <= '0;
      else     sk_q <= sk_d;
    end

    assign xbar_sel[s] = sk_q[s-1];
  end

  cram_out_fifo #(
    .W     (XREQ_SIZE * XDATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (xbar_out),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (rsp_data)
  );

`ifdef CRAM_CTRL_PERF_EN
  logic [31:0] perf_accept_cnt_q, perf_accept_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  always_comb begin
    perf_accept_cnt_d = perf_accept_cnt_q;
    perf_stall_cnt_d  = perf_stall_cnt_q;
    if (acc && (perf_accept_cnt_q != '1))
      perf_accept_cnt_d = perf_accept_cnt_q + 32'd1;
    if (req_valid && !req_ready && (perf_stall_cnt_q != '1))
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_accept_cnt_q <= '0;
      perf_stall_cnt_q  <= '0;
    end else begin
      perf_accept_cnt_q <= perf_accept_cnt_d;
      perf_stall_cnt_q  <= perf_stall_cnt_d;
    end
  end

  assign perf_accept_cnt = perf_accept_cnt_q;
  assign perf_stall_cnt  = perf_stall_cnt_q;
`endif

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst)
                    !(acc && !pop && outstanding_q == CW'(FIFO_DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
                    !(pop && !acc && outstanding_q == '0));
  a_credit_push:  assert property (@(posedge clk) disable iff (rst)
                    !(push && fifo_full));

endmodule
